// File: rtl/uart_pkg.sv
// Shared byte width and arbiter state encoding for the uart_tx requester arbiter.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr, with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // offset N lands back on ptr itself, so the previous winner is searched last
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter letting NREQ byte-stream requesters share one uart_tx, with
// message locking and an optional per-grant burst limit.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*BYTE_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   tx_req,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_ready,
    output logic [NREQ-1:0]        grant,
    output logic                   msg_cut
);

    localparam int PW     = $clog2(NREQ);
    localparam int CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam bit LIMIT_EN = (MAX_BURST != 0);
    localparam logic [CNT_W-1:0] CUT_AT = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    arb_state_t       state_reg, state_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cut_reg, cut_next;

    logic [BYTE_W-1:0] data_arr [NREQ];
    logic [NREQ-1:0]   pick;
    logic [PW-1:0]     pick_idx;
    logic              owner_valid;
    logic              accept;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (ptr_reg),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // ptr_reg doubles as the owner index while in OWN
    assign owner_valid = (state_reg == OWN) && req_valid[ptr_reg];
    assign accept      = owner_valid && tx_ready;
    assign tx_req      = owner_valid;
    assign tx_data     = (state_reg == OWN) ? data_arr[ptr_reg] : '0;
    assign req_ready   = grant_reg & {NREQ{accept}};
    assign grant       = grant_reg;
    assign msg_cut     = cut_reg;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= PW'(NREQ - 1);
            cnt_reg   <= '0;
            cut_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            cut_reg   <= cut_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        cut_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next = OWN;
                    grant_next = pick;
                    ptr_next   = pick_idx;
                    cnt_next   = '0;
                end
            end
            OWN: begin
                if (accept) begin
                    if (req_last[ptr_reg]) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end else if (LIMIT_EN && (cnt_reg == CUT_AT)) begin
                        state_next = IDLE;
                        grant_next = '0;
                        cut_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench: per-requester byte queues drive the arbiter, a cycle model of
// the arbitration rules predicts every output, plus directed ordering scenarios.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             reset_;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_req;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [N-1:0]     grant;
    logic             msg_cut;

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .msg_cut   (msg_cut)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] buf_mem [N][64];
    int         head [N];
    int         tail [N];
    bit         hold [N];
    int         tx_mode;
    int         cyc;

    int         m_own;
    int         m_last;
    int         m_cnt;
    bit         m_cut;

    int           dut_xfers;
    int           dut_cuts;
    logic [N-1:0] prev_grant;
    logic [N-1:0] dut_glog [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last);
        if (head[i] == tail[i]) begin
            head[i] = 0;
            tail[i] = 0;
        end
        buf_mem[i][tail[i]] = {last, d};
        tail[i]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i] && !hold[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = buf_mem[i][head[i]][7:0];
                req_last[i]        = buf_mem[i][head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = cyc[0];
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Reference: a transfer happens when the owner is valid and tx_ready is high;
    // idle cycles grant the first valid requester after the last winner.
    task automatic model_update();
        int w;
        bit found;
        m_cut = 1'b0;
        if (m_own < 0) begin
            if (|req_valid) begin
                found = 1'b0;
                w = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && req_valid[(m_last + k) % N]) begin
                        w = (m_last + k) % N;
                        found = 1'b1;
                    end
                end
                m_own  = w;
                m_last = w;
                m_cnt  = 0;
            end
        end else if (req_valid[m_own] && tx_ready) begin
            bit was_last;
            was_last = buf_mem[m_own][head[m_own]][8];
            head[m_own]++;
            m_cnt++;
            if (was_last) begin
                m_own = -1;
            end else if (MB != 0 && m_cnt == MB) begin
                m_own = -1;
                m_cut = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         etx;
        drive();
        #1;
        eg = '0;
        er = '0;
        etx = 1'b0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            etx = req_valid[m_own];
            if (etx && tx_ready) er[m_own] = 1'b1;
        end
        chk("grant", grant, eg);
        chk("tx_req", tx_req, etx);
        chk("req_ready", req_ready, er);
        chk("msg_cut", msg_cut, m_cut);
        if (etx) chk("tx_data", tx_data, buf_mem[m_own][head[m_own]][7:0]);
        if (tx_req && tx_ready) dut_xfers++;
        if (msg_cut) dut_cuts++;
        if (grant != '0 && prev_grant == '0) dut_glog.push_back(grant);
        prev_grant = grant;
        @(posedge clk);
        if (reset_) model_update();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        reset_ = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_msg_cut", msg_cut, 0);
        m_own  = -1;
        m_last = N - 1;
        m_cnt  = 0;
        m_cut  = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
        end
        prev_grant = '0;
        dut_glog.delete();
        dut_xfers = 0;
        dut_cuts  = 0;
        @(posedge clk);
        #1;
        step();
        reset_ = 1'b1;
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (!(all_empty() && m_own < 0) && n < maxc) begin
            step();
            n++;
        end
        step();
        chk(tag, (n < maxc) ? 1 : 0, 1);
    endtask

    task automatic run_until_xfers(input string tag, input int target, input int maxc);
        int n;
        n = 0;
        while (dut_xfers < target && n < maxc) begin
            step();
            n++;
        end
        chk(tag, (n < maxc) ? 1 : 0, 1);
    endtask

    initial begin
        reset_    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        tx_mode   = 0;
        cyc       = 0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // "Hey" from requester 0 with tx_ready toggling
        tx_mode = 1;
        push(0, 8'h48, 1'b0);
        push(0, 8'h65, 1'b0);
        push(0, 8'h79, 1'b1);
        run_until_idle("hey_done", 40);
        chk("hey_xfers", dut_xfers, 3);
        chk("hey_cuts", dut_cuts, 0);
        chk("hey_grant0", dut_glog[0], 4'b0001);
        chk("hey_ngrants", dut_glog.size(), 1);
        chk("hey_idle_grant", grant, 0);

        // requesters 0 and 2 after reset
        do_reset();
        tx_mode = 0;
        push(0, 8'hA0, 1'b1);
        push(2, 8'hA2, 1'b1);
        run_until_idle("two_done", 40);
        chk("two_g0", dut_glog[0], 4'b0001);
        chk("two_g1", dut_glog[1], 4'b0100);
        chk("two_xfers", dut_xfers, 2);

        // all four continuously valid, one-byte messages
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push(i, 8'(16 * i + r), 1'b1);
        end
        run_until_idle("rr_done", 80);
        chk("rr_g0", dut_glog[0], 4'b0001);
        chk("rr_g1", dut_glog[1], 4'b0010);
        chk("rr_g2", dut_glog[2], 4'b0100);
        chk("rr_g3", dut_glog[3], 4'b1000);
        chk("rr_g4", dut_glog[4], 4'b0001);
        chk("rr_xfers", dut_xfers, 8);

        // 6-byte message cut at 4; 4-byte message ending exactly at the limit
        do_reset();
        for (int b = 0; b < 6; b++) push(0, 8'(8'hC0 + b), (b == 5));
        push(1, 8'hD1, 1'b1);
        for (int b = 0; b < 4; b++) push(3, 8'(8'hE0 + b), (b == 3));
        run_until_idle("cut_done", 80);
        chk("cut_count", dut_cuts, 1);
        chk("cut_g0", dut_glog[0], 4'b0001);
        chk("cut_g1", dut_glog[1], 4'b0010);
        chk("cut_g2", dut_glog[2], 4'b1000);
        chk("cut_g3", dut_glog[3], 4'b0001);
        chk("cut_xfers", dut_xfers, 11);

        // owner stalls mid-message for 20 cycles while requester 1 waits
        do_reset();
        push(0, 8'h11, 1'b0);
        push(0, 8'h12, 1'b0);
        push(0, 8'h13, 1'b1);
        push(1, 8'h21, 1'b1);
        run_until_xfers("stall_first", 1, 20);
        hold[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("stall_grant", grant, 4'b0001);
            chk("stall_tx_req", tx_req, 0);
        end
        hold[0] = 1'b0;
        run_until_idle("stall_done", 40);
        chk("stall_g0", dut_glog[0], 4'b0001);
        chk("stall_g1", dut_glog[1], 4'b0010);
        chk("stall_xfers", dut_xfers, 4);

        // reset while byte 2 of 5 is presented
        do_reset();
        for (int b = 0; b < 5; b++) push(0, 8'(8'h50 + b), (b == 4));
        push(1, 8'h61, 1'b1);
        run_until_xfers("mid_first", 1, 20);
        drive();
        #1;
        chk("mid_pre_tx_req", tx_req, 1);
        do_reset();
        chk("mid_post_xfers", dut_xfers, 0);
        push(0, 8'h70, 1'b1);
        push(1, 8'h71, 1'b1);
        run_until_idle("mid_done", 40);
        chk("mid_g0", dut_glog[0], 4'b0001);
        chk("mid_g1", dut_glog[1], 4'b0010);

        // randomized traffic against the model
        do_reset();
        tx_mode = 2;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (head[i] == tail[i] && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 7);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1));
                end
                hold[i] = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        run_until_idle("rand_drain", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
